if_fetch_controller: RTL and testbench
======================================

// Module: if_fetch_controller
// PURPOSE
//  IF-stage PC/fetch controller. Consumes the EX-stage branch decision (PC_SEL plus target) and drives the instruction-memory handshake.
//  Delivers fetched instructions and their PCs to the IF/ID register, honouring hazard-unit stalls.
//  Discards wrong-path fetches on redirect and raises FLUSH for IF/ID and ID/EX.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  XLEN          32             address/data width (only 32 supported)
// PORTS
//  CLK            in   1     clock, rising edge
//  RESET          in   1     asynchronous, active-high reset
//  PC_SEL         in   1     redirect request from EX (1 = branch/jump taken)
//  BRANCH_TARGET  in   32    redirect target from EX
//  STALL          in   1     hazard unit: IF/ID may not accept an instruction
//  IMEM_REQ       out  1     fetch request valid
//  IMEM_ADDR      out  32    fetch address; stable while IMEM_REQ=1 and IMEM_READY=0
//  IMEM_READY     in   1     IMEM_RDATA valid, request complete this cycle
//  IMEM_RDATA     in   32    fetched instruction word
//  FETCH_VALID    out  1     INSTR/FETCH_PC valid for IF/ID this cycle
//  INSTR          out  32    instruction to IF/ID
//  FETCH_PC       out  32    PC of INSTR
//  FETCH_PC4      out  32    FETCH_PC + 4 (link address)
//  FLUSH          out  1     kill IF/ID and ID/EX contents at this edge
//  MISALIGNED     out  1     sticky: a target with [1:0] != 0 was seen
// BEHAVIOUR
//  Reset: PC=RESET_VECTOR, state=BOOT, hold buffer empty. IMEM_REQ=0, FETCH_VALID=0, FLUSH=0, MISALIGNED=0; INSTR, FETCH_PC, FETCH_PC4 = 0.
//  FSM states:
//   BOOT  -> FETCH after 1 cycle. REQ=0.
//   FETCH  REQ=1, ADDR=PC.
//   HOLD   REQ=0; the hold buffer drives INSTR.
//   DRAIN  REQ=1, ADDR=old PC; the response is discarded.
//  FETCH, READY=1, STALL=0, PC_SEL=0: FETCH_VALID=1 combinationally (INSTR=IMEM_RDATA, FETCH_PC=PC); PC<=PC+4. Zero-latency pass-through; 1 instr/cycle with READY tied high.
//  FETCH, READY=1, STALL=1: capture RDATA and PC into the hold buffer -> HOLD. FETCH_VALID=0.
//  HOLD, STALL=0: FETCH_VALID=1 from the buffer; PC<=PC+4 -> FETCH.
//  HOLD, STALL=1: hold all state.
//  PC_SEL=1 has priority over STALL and READY in every state except BOOT.
//   FLUSH=PC_SEL (combinational). FETCH_VALID forced 0 that cycle. MISALIGNED|=|BRANCH_TARGET[1:0].
//   Redirect PC = {BRANCH_TARGET[31:2],2'b00}.
//   FETCH with READY=1, or HOLD (buffer dropped): PC<=target; state becomes/stays FETCH.
//   FETCH with READY=0: the request cannot be withdrawn. Latch target in PEND -> DRAIN.
//   DRAIN with READY=0: a new PC_SEL overwrites PEND (newest wins).
//   DRAIN with READY=1: PC<=PEND -> FETCH. If PC_SEL=1 in the same cycle, BRANCH_TARGET wins over PEND.
//  PC_SEL in BOOT: PC<=target, FLUSH=1, BOOT->FETCH unchanged.
//  Arithmetic: PC+4 is modulo 2^32 (FFFF_FFFC -> 0000_0000). FETCH_PC4 is FETCH_PC+4, same wrap.
//  Reset mid-operation: an outstanding request is abandoned. The IMEM side must tolerate REQ dropping.
//  All state changes occur on the rising CLK edge; RESET overrides asynchronously.
// STRUCTURE
//  Shared header cpu_defs.vh: FSM state encodings (2 bits), RESET_VECTOR default, XLEN.
//  Sub-module fetch_hold_buffer: one-entry {INSTR,PC} register with load/clear/valid.
//  PC register, PEND register and FSM stay in this module.
// TESTING
//  1. Reset; READY=1, STALL=0 -> IMEM_ADDR 0,4,8,... each cycle; FETCH_VALID=1 from the 2nd cycle; FETCH_PC4=FETCH_PC+4.
//  2. READY=1; STALL=1 for 3 cycles when PC=8 -> state HOLD, REQ=0, FETCH_VALID=0. On release, INSTR from addr 8 is delivered once; the next ADDR is 0xC. No duplicate, no loss.
//  3. PC_SEL=1, target 0x100, while PC=0x10 with READY=1 -> FLUSH=1, FETCH_VALID=0 that cycle; next ADDR=0x100.
//  4. READY=0 at ADDR 0x20; PC_SEL target 0x200; READY returns after 2 cycles -> ADDR held at 0x20 until READY; that data discarded; next ADDR=0x200.
//  5. In DRAIN: second PC_SEL target 0x300, then READY with a third PC_SEL target 0x400 in the same cycle -> next ADDR=0x400.
//  6. Target 0x102 -> MISALIGNED=1 (sticky until RESET), ADDR=0x100. PC=FFFF_FFFC advances -> ADDR=0.

Source files
------------

// File: rtl/if_fetch_controller_pkg.sv
// Shared definitions for the IF-stage fetch controller: FSM encoding,
// default widths/reset vector and the redirect alignment helper.
package if_fetch_controller_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary; misalignment is only flagged.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_controller_hold_buffer.sv
// One-entry {instruction, PC} buffer that parks a fetched word while the
// decode stage is stalled.
module if_fetch_controller_hold_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_o
);

    logic         valid_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_q;

    // Load wins over clear so a capture is never lost in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage PC/fetch controller: drives the instruction-memory handshake,
// hands instructions to IF/ID under stalls and squashes wrong-path fetches.
module if_fetch_controller
    import if_fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned XLEN         = DEF_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_sel_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [XLEN-1:0] fetch_pc4_o,
    output logic            flush_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            misaligned_q, misaligned_d;

    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_instr, buf_pc;
    logic [XLEN-1:0] target;
    logic            show;
    logic [XLEN-1:0] out_instr, out_pc;

    assign target = align_target(branch_target_i);

    if_fetch_controller_hold_buffer #(
        .W (XLEN)
    ) u_hold_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata_i),
        .pc_i    (pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            pend_q       <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        misaligned_d  = misaligned_q | (pc_sel_i & (|branch_target_i[1:0]));
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_q;
        fetch_valid_o = 1'b0;
        flush_o       = pc_sel_i;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        show          = 1'b0;
        out_instr     = '0;
        out_pc        = '0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (pc_sel_i) begin
                    pc_d = target;
                end
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (pc_sel_i) begin
                    // An unanswered request cannot be withdrawn, so park the target.
                    if (imem_ready_i) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (stall_i) begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        fetch_valid_o = 1'b1;
                        show          = 1'b1;
                        out_instr     = imem_rdata_i;
                        out_pc        = pc_q;
                        pc_d          = pc_q + PC_STEP;
                    end
                end
            end
            ST_HOLD: begin
                show      = buf_valid;
                out_instr = buf_instr;
                out_pc    = buf_pc;
                if (pc_sel_i) begin
                    buf_clear = 1'b1;
                    pc_d      = target;
                    state_d   = ST_FETCH;
                end else if (!stall_i) begin
                    fetch_valid_o = 1'b1;
                    buf_clear     = 1'b1;
                    pc_d          = pc_q + PC_STEP;
                    state_d       = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    pc_d    = pc_sel_i ? target : pend_q;
                    state_d = ST_FETCH;
                end else if (pc_sel_i) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign instr_o      = out_instr;
    assign fetch_pc_o   = out_pc;
    assign fetch_pc4_o  = show ? (out_pc + PC_STEP) : '0;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_if_fetch_controller;

    logic        clk;
    logic        rst;
    logic        pc_sel;
    logic [31:0] target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc4;
    logic        flush;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: the word returned is a fixed scramble of its address.
    assign imem_rdata = instrOf(imem_addr);

    if_fetch_controller dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_sel_i        (pc_sel),
        .branch_target_i (target),
        .stall_i         (stall),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ready_i    (imem_ready),
        .imem_rdata_i    (imem_rdata),
        .fetch_valid_o   (fetch_valid),
        .instr_o         (instr),
        .fetch_pc_o      (fetch_pc),
        .fetch_pc4_o     (fetch_pc4),
        .flush_o         (flush),
        .misaligned_o    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH with PC at the reset vector and all inputs idle.
    task automatic doReset();
        rst = 1'b1; pc_sel = 1'b0; stall = 1'b0; imem_ready = 1'b0; target = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_sel = 1'b0; stall = 1'b0; imem_ready = 1'b1; target = '0;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", fetch_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush: got %b expected 0", flush); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("[TB] FAIL rst_misaligned: got %b expected 0", misaligned); end
        checks++; if ({instr, fetch_pc, fetch_pc4} !== 96'h0) begin errors++; $display("[TB] FAIL rst_outputs: got %h %h %h expected zeros", instr, fetch_pc, fetch_pc4); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_req: got %b expected 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_valid: got %b expected 0", fetch_valid); end
    endtask

    task automatic test_boot_redirect();
        rst = 1'b1; pc_sel = 1'b0; stall = 1'b0; imem_ready = 1'b1; target = '0;
        step();
        rst = 1'b0; pc_sel = 1'b1; target = 32'h40;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL boot_flush: got %b expected 1", flush); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_sel_req: got %b expected 0", imem_req); end
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL boot_target_addr: got %h expected 00000040", imem_addr); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL boot_target_valid: got %b expected 1", fetch_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        doReset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            #1;
            checks++; if (imem_addr !== exp) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, exp); end
            checks++; if (fetch_valid !== 1'b1 || fetch_pc !== exp) begin errors++; $display("[TB] FAIL seq_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, fetch_valid, fetch_pc, exp); end
            checks++; if (instr !== instrOf(exp)) begin errors++; $display("[TB] FAIL seq_instr[%0d]: got %h expected %h", i, instr, instrOf(exp)); end
            checks++; if (fetch_pc4 !== exp + 32'd4) begin errors++; $display("[TB] FAIL seq_pc4[%0d]: got %h expected %h", i, fetch_pc4, exp + 32'd4); end
            step();
        end
    endtask

    task automatic test_stall();
        doReset();
        imem_ready = 1'b1;
        step();
        step();
        stall = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h8 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_capture: got addr=%h v=%b expected addr=00000008 v=0", imem_addr, fetch_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got req=%b v=%b expected req=0 v=0", i, imem_req, fetch_valid); end
        end
        step();
        stall = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8) begin errors++; $display("[TB] FAIL stall_release: got v=%b pc=%h expected v=1 pc=00000008", fetch_valid, fetch_pc); end
        checks++; if (instr !== instrOf(32'h8)) begin errors++; $display("[TB] FAIL stall_release_instr: got %h expected %h", instr, instrOf(32'h8)); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_req: got %b expected 0", imem_req); end
        step();
        checks++; if (imem_addr !== 32'hC || fetch_pc !== 32'hC || fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_next: got addr=%h pc=%h v=%b expected addr=0000000c pc=0000000c v=1", imem_addr, fetch_pc, fetch_valid); end
    endtask

    task automatic test_redirect();
        doReset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pc_sel = 1'b1; target = 32'h100;
        #1;
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 00000010", imem_addr); end
        checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got flush=%b v=%b expected flush=1 v=0", flush, fetch_valid); end
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h100 || flush !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_next: got addr=%h flush=%b v=%b expected addr=00000100 flush=0 v=1", imem_addr, flush, fetch_valid); end
    endtask

    task automatic test_drain();
        doReset();
        imem_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        imem_ready = 1'b0; pc_sel = 1'b1; target = 32'h200;
        #1;
        checks++; if (imem_addr !== 32'h20 || flush !== 1'b1) begin errors++; $display("[TB] FAIL drain_start: got addr=%h flush=%b expected addr=00000020 flush=1", imem_addr, flush); end
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_wait: got req=%b addr=%h v=%b expected req=1 addr=00000020 v=0", imem_req, imem_addr, fetch_valid); end
        step();
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_discard: got addr=%h v=%b expected addr=00000020 v=0", imem_addr, fetch_valid); end
        step();
        checks++; if (imem_addr !== 32'h200 || fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_next: got addr=%h v=%b expected addr=00000200 v=1", imem_addr, fetch_valid); end
    endtask

    task automatic test_back_to_back();
        doReset();
        pc_sel = 1'b1; target = 32'h80;
        step();
        target = 32'h300;
        step();
        imem_ready = 1'b1; target = 32'h400;
        #1;
        checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush: got flush=%b v=%b expected flush=1 v=0", flush, fetch_valid); end
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h400) begin errors++; $display("[TB] FAIL b2b_newest: got %h expected 00000400", imem_addr); end
        doReset();
        pc_sel = 1'b1; target = 32'h80;
        step();
        target = 32'h300;
        step();
        pc_sel = 1'b0; imem_ready = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL b2b_pend: got %h expected 00000300", imem_addr); end
    endtask

    task automatic test_misaligned_wrap();
        doReset();
        imem_ready = 1'b1;
        pc_sel = 1'b1; target = 32'h102;
        #1;
        checks++; if (misaligned !== 1'b0) begin errors++; $display("[TB] FAIL mis_before: got %b expected 0", misaligned); end
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (misaligned !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL mis_set: got mis=%b addr=%h expected mis=1 addr=00000100", misaligned, imem_addr); end
        pc_sel = 1'b1; target = 32'hFFFF_FFFC;
        step();
        pc_sel = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || fetch_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4: got addr=%h pc4=%h expected addr=fffffffc pc4=00000000", imem_addr, fetch_pc4); end
        step();
        checks++; if (imem_addr !== 32'h0 || misaligned !== 1'b1) begin errors++; $display("[TB] FAIL wrap_addr: got addr=%h mis=%b expected addr=00000000 mis=1", imem_addr, misaligned); end
        doReset();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("[TB] FAIL mis_cleared: got %b expected 0", misaligned); end
    endtask

    initial begin
        test_reset();
        test_boot_redirect();
        test_sequential();
        test_stall();
        test_redirect();
        test_drain();
        test_back_to_back();
        test_misaligned_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
